// File: rtl/pci_mst_cmdadr.sv
// PCI initiator command/address sequencer: arbitrates for the bus, drives the
// address phase, then runs a linear burst until completion, STOP# or master abort.
module pci_mst_cmdadr #(
  parameter int BURST_W   = 8,
  parameter int DEVSEL_TO = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [3:0]         req_cmd,
  input  logic [31:0]        req_adr,
  input  logic [BURST_W-1:0] req_len,
  output logic               req_ack,
  input  logic               gntnid,
  input  logic               framenid,
  input  logic               irdynid,
  input  logic               trdynid,
  input  logic               stopnid,
  input  logic               devselnid,
  output logic               framen_o,
  output logic               framen_oe,
  output logic               irdyn_o,
  output logic               irdyn_oe,
  output logic               ad_oe,
  output logic [31:0]        adr_o,
  output logic [3:0]         cbe_o,
  output logic               dat_adv,
  output logic [BURST_W-1:0] rem_len,
  output logic               mst_busy,
  output logic               mst_done,
  output logic               mst_retry,
  output logic               mst_abort
);

  localparam int CNT_W = $clog2(DEVSEL_TO + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, LAST, TURN} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        adr_reg, adr_next;
  logic [3:0]         cmd_reg, cmd_next;
  logic [BURST_W-1:0] rem_reg, rem_next;
  logic [CNT_W-1:0]   dcnt_reg, dcnt_next;
  logic               dsel_reg, dsel_next;
  logic               done_reg, done_next;
  logic               retry_reg, retry_next;
  logic               abort_reg, abort_next;

  logic               xfer;
  logic               dev_to;
  logic               beat;
  logic [BURST_W-1:0] rem_after;

  // IRDY# is always asserted by us in DATA/LAST, so a beat needs only TRDY#.
  assign xfer      = (state_reg == DATA) || (state_reg == LAST);
  assign dev_to    = xfer && !dsel_reg && devselnid && (dcnt_reg == CNT_W'(DEVSEL_TO - 1));
  assign beat      = xfer && !trdynid && !dev_to;
  assign rem_after = beat ? rem_reg - BURST_W'(1) : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      adr_reg   <= '0;
      cmd_reg   <= '0;
      rem_reg   <= '0;
      dcnt_reg  <= '0;
      dsel_reg  <= 1'b0;
      done_reg  <= 1'b0;
      retry_reg <= 1'b0;
      abort_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      adr_reg   <= adr_next;
      cmd_reg   <= cmd_next;
      rem_reg   <= rem_next;
      dcnt_reg  <= dcnt_next;
      dsel_reg  <= dsel_next;
      done_reg  <= done_next;
      retry_reg <= retry_next;
      abort_reg <= abort_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    adr_next   = adr_reg;
    cmd_next   = cmd_reg;
    rem_next   = rem_reg;
    dcnt_next  = dcnt_reg;
    dsel_next  = dsel_reg;
    done_next  = 1'b0;
    retry_next = 1'b0;
    abort_next = 1'b0;

    // DEVSEL# timeout counter freezes for the rest of the burst once DEVSEL# is seen.
    if (xfer) begin
      if (!devselnid)
        dsel_next = 1'b1;
      else if (!dsel_reg)
        dcnt_next = dcnt_reg + CNT_W'(1);
    end

    if (beat) begin
      adr_next = {adr_reg[31:2] + 30'd1, adr_reg[1:0]};
      rem_next = rem_after;
    end

    unique case (state_reg)
      IDLE: begin
        if (req && !gntnid && framenid && irdynid) begin
          state_next = ADDR;
          cmd_next   = req_cmd;
          // Only I/O commands carry meaningful low address bits.
          adr_next   = {req_adr[31:2], (req_cmd[3:1] == 3'b001) ? req_adr[1:0] : 2'b00};
          rem_next   = (req_len == '0) ? BURST_W'(1) : req_len;
        end
      end
      ADDR: begin
        state_next = DATA;
        dcnt_next  = '0;
        dsel_next  = 1'b0;
      end
      DATA: begin
        if (dev_to) begin
          state_next = TURN;
          abort_next = 1'b1;
        end else if (beat && rem_reg == BURST_W'(1)) begin
          state_next = TURN;
          done_next  = 1'b1;
        end else if (!stopnid) begin
          state_next = LAST;
        end
      end
      LAST: begin
        if (dev_to) begin
          state_next = TURN;
          abort_next = 1'b1;
        end else if (!trdynid || !stopnid) begin
          state_next = TURN;
          retry_next = (rem_after != '0);
          done_next  = (rem_after == '0);
        end
      end
      TURN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    framen_o  = 1'b1;
    framen_oe = 1'b0;
    irdyn_o   = 1'b1;
    irdyn_oe  = 1'b0;
    ad_oe     = 1'b0;
    cbe_o     = 4'hF;
    unique case (state_reg)
      IDLE: ;
      ADDR: begin
        framen_o  = 1'b0;
        framen_oe = 1'b1;
        irdyn_oe  = 1'b1;
        ad_oe     = 1'b1;
        cbe_o     = cmd_reg;
      end
      DATA: begin
        framen_o  = (rem_reg == BURST_W'(1));
        framen_oe = 1'b1;
        irdyn_o   = 1'b0;
        irdyn_oe  = 1'b1;
        ad_oe     = cmd_reg[0];
        cbe_o     = 4'b0000;
      end
      LAST: begin
        framen_oe = 1'b1;
        irdyn_o   = 1'b0;
        irdyn_oe  = 1'b1;
        ad_oe     = cmd_reg[0];
        cbe_o     = 4'b0000;
      end
      TURN: begin
        framen_oe = 1'b1;
        irdyn_oe  = 1'b1;
        cbe_o     = 4'b0000;
      end
      default: ;
    endcase
  end

  assign dat_adv   = beat;
  assign adr_o     = adr_reg;
  assign rem_len   = rem_reg;
  assign req_ack   = (state_reg == ADDR);
  assign mst_busy  = (state_reg != IDLE);
  assign mst_done  = done_reg;
  assign mst_retry = retry_reg;
  assign mst_abort = abort_reg;

endmodule

// File: tb/tb_pci_mst_cmdadr.sv
// Bench for pci_mst_cmdadr: table of bursts driven against a simple PCI target
// responder, with a scoreboard queue of expected burst outcomes.
module tb_pci_mst_cmdadr;

  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               req;
  logic [3:0]         req_cmd;
  logic [31:0]        req_adr;
  logic [BURST_W-1:0] req_len;
  logic               req_ack;
  logic               gntnid;
  logic               framenid;
  logic               irdynid;
  logic               trdynid = 1'b1;
  logic               stopnid = 1'b1;
  logic               devselnid = 1'b1;
  logic               framen_o, framen_oe, irdyn_o, irdyn_oe, ad_oe;
  logic [31:0]        adr_o;
  logic [3:0]         cbe_o;
  logic               dat_adv;
  logic [BURST_W-1:0] rem_len;
  logic               mst_busy, mst_done, mst_retry, mst_abort;

  pci_mst_cmdadr #(.BURST_W(BURST_W), .DEVSEL_TO(5)) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_adr(req_adr),
    .req_len(req_len), .req_ack(req_ack), .gntnid(gntnid), .framenid(framenid),
    .irdynid(irdynid), .trdynid(trdynid), .stopnid(stopnid), .devselnid(devselnid),
    .framen_o(framen_o), .framen_oe(framen_oe), .irdyn_o(irdyn_o), .irdyn_oe(irdyn_oe),
    .ad_oe(ad_oe), .adr_o(adr_o), .cbe_o(cbe_o), .dat_adv(dat_adv), .rem_len(rem_len),
    .mst_busy(mst_busy), .mst_done(mst_done), .mst_retry(mst_retry), .mst_abort(mst_abort)
  );

  always #5 clk = ~clk;

  // kind: 0 done, 1 retry, 2 abort; exp_cycles counts clocks from ADDR to IDLE
  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] adr;
    logic [7:0]  len;
    int          waits;
    int          stop_beat;
    bit          devsel;
    int          kind;
    logic [7:0]  exp_rem;
    logic [31:0] exp_adr;
    logic [31:0] ap_adr;
    int          exp_beats;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  int   errors = 0;
  int   checks = 0;
  int   cur_waits = 0;
  int   cur_stop = 0;
  bit   cur_devsel = 1'b1;
  int   wait_cnt = 0;
  int   beat_idx = 0;
  int   m_beats = 0;
  logic [7:0] m_rem = '0;
  bit   m_stopped = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Target responder followed by the output monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst && mst_busy && irdyn_oe && !irdyn_o) begin
      wait_cnt++;
      devselnid = !cur_devsel;
      if (cur_devsel && wait_cnt > cur_waits) begin
        trdynid = 1'b0;
        stopnid = !(cur_stop != 0 && beat_idx + 1 >= cur_stop);
        beat_idx++;
      end else begin
        trdynid = 1'b1;
        stopnid = 1'b1;
      end
    end else begin
      trdynid   = 1'b1;
      stopnid   = 1'b1;
      devselnid = 1'b1;
      wait_cnt  = 0;
      beat_idx  = 0;
    end
    #1;
    if (!rst) begin
      if (req_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_req_ack", 32'd1, 32'd0);
        end else begin
          chk("ap_adr", adr_o, sb[0].ap_adr);
          chk("ap_cbe", {28'd0, cbe_o}, {28'd0, sb[0].cmd});
          chk("ap_drive", {27'd0, framen_o, framen_oe, irdyn_o, irdyn_oe, ad_oe}, 32'b01111);
          m_rem     = (sb[0].len == 8'd0) ? 8'd1 : sb[0].len;
          chk("ap_rem", {24'd0, rem_len}, {24'd0, m_rem});
          m_beats   = 0;
          m_stopped = 1'b0;
        end
      end
      if (mst_busy && irdyn_oe && !irdyn_o && sb.size() != 0) begin
        chk("data_cbe", {28'd0, cbe_o}, 32'd0);
        chk("data_ad_oe", {31'd0, ad_oe}, {31'd0, sb[0].cmd[0]});
        chk("data_frame", {31'd0, framen_o}, {31'd0, (m_stopped || m_rem == 8'd1)});
        chk("data_rem", {24'd0, rem_len}, {24'd0, m_rem});
        if (dat_adv) begin
          chk("beat_adr", adr_o, sb[0].ap_adr + 32'(4 * m_beats));
          m_beats++;
          m_rem = m_rem - 8'd1;
        end
        if (!stopnid) m_stopped = 1'b1;
      end
      if (mst_done || mst_retry || mst_abort) begin
        if (sb.size() == 0) begin
          chk("unexpected_end_pulse", 32'd1, 32'd0);
        end else begin
          vec_t f;
          int   k;
          f = sb.pop_front();
          k = mst_done ? 0 : (mst_retry ? 1 : 2);
          chk("one_pulse", 32'(int'(mst_done) + int'(mst_retry) + int'(mst_abort)), 32'd1);
          chk("end_kind", 32'(k), 32'(f.kind));
          chk("end_rem", {24'd0, rem_len}, {24'd0, f.exp_rem});
          chk("end_adr", adr_o, f.exp_adr);
          chk("end_beats", 32'(m_beats), 32'(f.exp_beats));
          chk("turn_drive", {27'd0, framen_o, framen_oe, irdyn_o, irdyn_oe, ad_oe}, 32'b11110);
        end
      end
    end
  end

  task automatic run(input vec_t v);
    int n;
    bit seen;
    @(negedge clk); #2;
    cur_waits  = v.waits;
    cur_stop   = v.stop_beat;
    cur_devsel = v.devsel;
    req_cmd    = v.cmd;
    req_adr    = v.adr;
    req_len    = v.len;
    req        = 1'b1;
    gntnid     = 1'b0;
    sb.push_back(v);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #2;
      if (req_ack) seen = 1'b1;
    end
    chk("req_ack_seen", {31'd0, seen}, 32'd1);
    req    = 1'b0;
    gntnid = 1'b1;
    n = 0;
    while (mst_busy && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    chk("busy_cycles", 32'(n), 32'(v.exp_cycles));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
    $display("burst cmd=%h adr=%h len=%0d: cycles=%0d rem=%0d adr_o=%h", v.cmd, v.adr, v.len, n, rem_len, adr_o);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    int   pulses;
    bit   seen;
    //          cmd    adr            len  wt st dv kind rem    end_adr        ap_adr         beats cyc
    vecs[0] = '{4'h7, 32'h0000_1000, 8'd4, 0, 0, 1'b1, 0, 8'd0, 32'h0000_1010, 32'h0000_1000, 4, 6};
    vecs[1] = '{4'h6, 32'h0000_0020, 8'd1, 2, 0, 1'b1, 0, 8'd0, 32'h0000_0024, 32'h0000_0020, 1, 5};
    vecs[2] = '{4'h6, 32'h0000_4000, 8'd8, 0, 3, 1'b1, 1, 8'd4, 32'h0000_4010, 32'h0000_4000, 4, 6};
    vecs[3] = '{4'h7, 32'h0000_8000, 8'd2, 0, 0, 1'b0, 2, 8'd2, 32'h0000_8000, 32'h0000_8000, 0, 7};
    vecs[4] = '{4'h2, 32'h0000_03F2, 8'd1, 0, 0, 1'b1, 0, 8'd0, 32'h0000_03F6, 32'h0000_03F2, 1, 3};
    vecs[5] = '{4'h6, 32'h0000_03F2, 8'd1, 0, 0, 1'b1, 0, 8'd0, 32'h0000_03F4, 32'h0000_03F0, 1, 3};
    vecs[6] = '{4'h7, 32'hFFFF_FFFC, 8'd0, 0, 0, 1'b1, 0, 8'd0, 32'h0000_0000, 32'hFFFF_FFFC, 1, 3};
    vecs[7] = '{4'h7, 32'h0000_2000, 8'd2, 0, 2, 1'b1, 0, 8'd0, 32'h0000_2008, 32'h0000_2000, 2, 4};
    vecs[8] = '{4'h6, 32'h0000_3000, 8'd3, 0, 1, 1'b1, 1, 8'd1, 32'h0000_3008, 32'h0000_3000, 2, 4};

    rst = 1'b1; req = 1'b0; gntnid = 1'b1; framenid = 1'b1; irdynid = 1'b1;
    req_cmd = '0; req_adr = '0; req_len = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_drive", {27'd0, framen_o, framen_oe, irdyn_o, irdyn_oe, ad_oe}, 32'b10100);
    chk("reset_adr", adr_o, 32'd0);
    chk("reset_cbe", {28'd0, cbe_o}, 32'hF);
    chk("reset_rem", {24'd0, rem_len}, 32'd0);
    chk("reset_flags", {26'd0, mst_busy, req_ack, mst_done, mst_retry, mst_abort, dat_adv}, 32'd0);
    rst = 1'b0;

    // Request must wait while FRAME# is busy or GNT# is not given.
    req = 1'b1; req_cmd = 4'h7; req_adr = 32'h100; req_len = 8'd1;
    gntnid = 1'b0; framenid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("hold_frame_busy", {30'd0, mst_busy, req_ack}, 32'd0);
    framenid = 1'b1; gntnid = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("hold_no_gnt", {30'd0, mst_busy, req_ack}, 32'd0);
    req = 1'b0;

    for (int i = 0; i < 9; i++) run(vecs[i]);

    // Reset in the middle of a long burst stalled by TRDY#.
    r = '{4'h6, 32'h0000_5000, 8'd8, 1000, 0, 1'b1, 0, 8'd0, 32'h0, 32'h0000_5000, 0, 0};
    @(negedge clk); #2;
    cur_waits = r.waits; cur_stop = 0; cur_devsel = 1'b1;
    req_cmd = r.cmd; req_adr = r.adr; req_len = r.len; req = 1'b1; gntnid = 1'b0;
    sb.push_back(r);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #2;
      if (req_ack) seen = 1'b1;
    end
    chk("rst_req_ack_seen", {31'd0, seen}, 32'd1);
    req = 1'b0; gntnid = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("pre_reset_data", {30'd0, mst_busy, irdyn_o}, 32'b10);
    rst = 1'b1;
    @(negedge clk); #2;
    chk("mid_rst_busy", {31'd0, mst_busy}, 32'd0);
    chk("mid_rst_oe", {29'd0, framen_oe, irdyn_oe, ad_oe}, 32'd0);
    chk("mid_rst_rem", {24'd0, rem_len}, 32'd0);
    chk("mid_rst_cbe", {28'd0, cbe_o}, 32'hF);
    sb.delete();
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk); #2;
      pulses += int'(mst_done) + int'(mst_retry) + int'(mst_abort) + int'(mst_busy);
    end
    chk("no_activity_after_rst", 32'(pulses), 32'd0);
    $display("reset mid-burst: busy=%0d rem=%0d", mst_busy, rem_len);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
